// File: rtl/stoper_pkg.sv
// Shared definitions for the stopwatch button front-end: debounce FSM states,
// counter widths and default timing constants.
package stoper_pkg;

    localparam int unsigned CNT_W = 15;
    localparam int unsigned PER_W = 8;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32000;
    localparam int unsigned DEFAULT_LONG_PERIODS    = 50;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        LONG_HELD,
        RELEASE_WAIT
    } state_t;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for an asynchronous button line; resets to 1 (released
// level for active-low buttons).
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;
    logic stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b1;
            stable <= 1'b1;
        end else begin
            meta   <= din;
            stable <= meta;
        end
    end

    assign dout = stable;

endmodule

// File: rtl/button_debounce.sv
// Debounces one active-low push-button into a clean level plus single-cycle
// press / release / long_press events. The release event port is release_pulse.
module button_debounce
    import stoper_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PERIODS    = DEFAULT_LONG_PERIODS
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PER_W-1:0] PER_LIMIT = PER_W'(LONG_PERIODS);

    logic             sync_n;
    logic             s;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [PER_W-1:0] per;
    logic [PER_W-1:0] per_inc;
    logic             long_fired;

    btn_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_n),
        .dout (sync_n)
    );

    assign s       = ~sync_n;
    assign per_inc = per + PER_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            per           <= '0;
            long_fired    <= 1'b0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state      <= PRESSED;
                        press      <= 1'b1;
                        level      <= 1'b1;
                        cnt        <= '0;
                        per        <= '0;
                        long_fired <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        // Completed one debounce period while held.
                        cnt <= '0;
                        per <= per_inc;
                        if (per_inc == PER_LIMIT) begin
                            long_press <= 1'b1;
                            long_fired <= 1'b1;
                            state      <= LONG_HELD;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LONG_HELD: begin
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        // Release glitch rejected; per is kept so progress survives.
                        state <= long_fired ? LONG_HELD : PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        level         <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_PERIODS=3;
// outputs are checked every cycle against hand-computed {level,press,release,long}.
module tb_button_debounce;

    localparam int unsigned DC = 4;
    localparam int unsigned LP = 3;

    localparam logic [3:0] Z  = 4'b0000;
    localparam logic [3:0] L  = 4'b1000;
    localparam logic [3:0] P  = 4'b1100;
    localparam logic [3:0] R  = 4'b0010;
    localparam logic [3:0] LG = 4'b1001;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic btn_n = 1'b1;
    logic level;
    logic press;
    logic release_pulse;
    logic long_press;

    int checks    = 0;
    int failures  = 0;
    int long_seen = 0;

    typedef struct packed {
        logic       rst;
        logic       btn_n;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];

    button_debounce #(
        .DEBOUNCE_CYCLES (DC),
        .LONG_PERIODS    (LP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_n         (btn_n),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    always #5 clk = ~clk;

    task automatic add(input int n, input logic r, input logic b, input logic [3:0] e);
        for (int i = 0; i < n; i++) vecs.push_back('{rst: r, btn_n: b, exp: e});
    endtask

    // Drive one cycle, then check outputs 1 time unit after the rising edge.
    task automatic apply(input string name, input logic r, input logic b, input logic [3:0] e);
        logic [3:0] got;
        rst   = r;
        btn_n = b;
        @(posedge clk);
        #1;
        got = {level, press, release_pulse, long_press};
        long_seen += int'(long_press);
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s step %0d: {level,press,release,long} got %b required %b",
                     name, checks, got, e);
        end
    endtask

    task automatic run(input string name, input int n, input logic r, input logic b,
                       input logic [3:0] e);
        for (int i = 0; i < n; i++) apply(name, r, b, e);
    endtask

    task automatic check_long(input string name, input int required);
        checks++;
        if (long_seen != required) begin
            failures++;
            $display("FAIL %s: long_press pulses got %0d required %0d",
                     name, long_seen, required);
        end
    endtask

    initial begin
        // Reset with button held, press after release of rst, then clean release.
        add(3, 1'b1, 1'b0, Z);
        add(6, 1'b0, 1'b0, Z);
        add(1, 1'b0, 1'b0, P);
        add(4, 1'b0, 1'b0, L);
        add(6, 1'b0, 1'b1, L);
        add(1, 1'b0, 1'b1, R);
        add(3, 1'b0, 1'b1, Z);
        // Bounce: 3 low / 1 high never completes the debounce window.
        for (int k = 0; k < 10; k++) begin
            add(3, 1'b0, 1'b0, Z);
            add(1, 1'b0, 1'b1, Z);
        end
        add(6, 1'b0, 1'b1, Z);
        // Clean press held 30 cycles: long_press 12 cycles after press.
        add(6, 1'b0, 1'b0, Z);
        add(1, 1'b0, 1'b0, P);
        add(11, 1'b0, 1'b0, L);
        add(1, 1'b0, 1'b0, LG);
        add(18, 1'b0, 1'b0, L);
        add(6, 1'b0, 1'b1, L);
        add(1, 1'b0, 1'b1, R);
        add(2, 1'b0, 1'b1, Z);

        for (int i = 0; i < vecs.size(); i++) begin
            apply("table", vecs[i].rst, vecs[i].btn_n, vecs[i].exp);
        end
        check_long("table_long_once", 1);

        // Two-cycle release glitch right after the first period wrap: the FSM
        // spends two cycles in RELEASE_WAIT plus one re-entry cycle, with cnt=0
        // lost, so long_press moves from press+12 to press+15.
        long_seen = 0;
        run("glitch", 6, 1'b0, 1'b0, Z);
        run("glitch", 1, 1'b0, 1'b0, P);
        run("glitch", 2, 1'b0, 1'b0, L);
        run("glitch", 2, 1'b0, 1'b1, L);
        run("glitch", 10, 1'b0, 1'b0, L);
        run("glitch", 1, 1'b0, 1'b0, LG);
        run("glitch", 4, 1'b0, 1'b0, L);
        run("glitch", 6, 1'b0, 1'b1, L);
        run("glitch", 1, 1'b0, 1'b1, R);
        run("glitch", 2, 1'b0, 1'b1, Z);
        check_long("glitch_long_once", 1);

        // Reset while PRESSED: outputs clear immediately, fresh press afterwards.
        long_seen = 0;
        run("rst_mid", 6, 1'b0, 1'b0, Z);
        run("rst_mid", 1, 1'b0, 1'b0, P);
        run("rst_mid", 2, 1'b0, 1'b0, L);
        run("rst_mid", 2, 1'b1, 1'b0, Z);
        run("rst_mid", 6, 1'b0, 1'b0, Z);
        run("rst_mid", 1, 1'b0, 1'b0, P);
        run("rst_mid", 3, 1'b0, 1'b0, L);
        run("rst_mid", 6, 1'b0, 1'b1, L);
        run("rst_mid", 1, 1'b0, 1'b1, R);
        run("rst_mid", 2, 1'b0, 1'b1, Z);
        check_long("rst_mid_no_long", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
